bus_arbiter_n: RTL and testbench

- Parametrised N-master arbiter for the shared system bus.
- Replaces the hard-wired VGA/UART/CPU muxing with one registered grant per transaction.
- Supports fixed-priority or round-robin selection and a per-transaction ack timeout.
- Drives a single slave-side port (RAM/peripheral decoder) and returns ack/error per master.

---
 rtl/bus_arbiter_n_pkg.sv | 19 +
 rtl/bus_arbiter_n_picker.sv | 38 +++
 rtl/bus_arbiter_n.sv | 138 +++++++++++++
 tb/tb_bus_arbiter_n.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_n_pkg.sv
// Shared types and helpers for the N-master system bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arbiter_n_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Low bit of master k's slice in a flattened per-master bus of width w.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/bus_arbiter_n_picker.sv
// rr_priority_picker: one-hot winner from a request vector, fixed or round-robin.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is taken.
// Ports: req (request vector), ptr (last winner, rr mode only), rr_mode,
//        winner (one-hot), win_idx (binary index of winner), found (any req).
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = (N < 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr_mode,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] win_idx,
  output logic          found
);

  logic [IW-1:0] idx;

  // Fixed mode scans 0..N-1; round-robin scans ptr+1, ptr+2, ... modulo N,
  // so the previous winner is considered last.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N; off++) begin
      if (rr_mode) idx = IW'((int'(ptr) + off) % N);
      else         idx = IW'(off - 1);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master shared-bus arbiter with registered one-hot grant.
// Latency: grant registers 1 cycle after req in IDLE; ack/err are same-cycle.
// Backpressure: masters hold req until ack/err; one mandatory IDLE cycle per transaction.
// Ports: i_clk, i_reset (sync, high); per-master i_m_req/i_m_we/i_m_addr/i_m_dat in,
//        o_m_grant/o_m_ack/o_m_err out; slave side o_cs/o_we/o_addr/o_dat out,
//        i_dat/i_ack in; o_rdat is i_dat broadcast; o_busy high while BUSY.
module bus_arbiter_n
  import bus_arbiter_n_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_MASTERS-1:0]      i_m_req,
  input  logic [NUM_MASTERS-1:0]      i_m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat,
  output logic [NUM_MASTERS-1:0]      o_m_grant,
  output logic [NUM_MASTERS-1:0]      o_m_ack,
  output logic [NUM_MASTERS-1:0]      o_m_err,
  output logic [DATA_W-1:0]           o_rdat,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [DATA_W-1:0]           o_dat,
  output logic                        o_we,
  output logic                        o_cs,
  input  logic [DATA_W-1:0]           i_dat,
  input  logic                        i_ack,
  output logic                        o_busy
);

  localparam int PTR_W = (NUM_MASTERS < 2) ? 1 : $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Counter reads 0 on the first BUSY cycle, so the TIMEOUT-th cycle sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0]     pick;
  logic [PTR_W-1:0]           pick_idx;
  logic                       pick_any;
  logic                       busy;
  logic                       granted_req;
  logic                       timeout_hit;
  logic [ADDR_W-1:0]          addr_mux;
  logic [DATA_W-1:0]          dat_mux;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .IW (PTR_W)
  ) u_picker (
    .req     (i_m_req),
    .ptr     (ptr_q),
    .rr_mode (RR_MODE != 0),
    .winner  (pick),
    .win_idx (pick_idx),
    .found   (pick_any)
  );

  assign busy        = (state_q == BUSY);
  assign granted_req = |(i_m_req & grant_q);
  // Ack has priority over timeout; a dropped request aborts silently.
  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt_q == CNT_LAST)
                       && !i_ack && granted_req;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          state_d = BUSY;
          grant_d = pick;
          ptr_d   = pick_idx;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (i_ack || !granted_req || timeout_hit) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant is one-hot (or zero), so OR-ing the selected slices is a clean mux.
  always_comb begin
    addr_mux = '0;
    dat_mux  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        addr_mux = addr_mux | i_m_addr[slice_lo(k, ADDR_W) +: ADDR_W];
        dat_mux  = dat_mux  | i_m_dat[slice_lo(k, DATA_W) +: DATA_W];
      end
    end
  end

  assign o_m_grant = grant_q;
  assign o_m_ack   = {NUM_MASTERS{i_ack & busy}} & grant_q;
  assign o_m_err   = {NUM_MASTERS{timeout_hit}} & grant_q;
  assign o_busy    = busy;
  assign o_cs      = busy;
  assign o_we      = busy & |(i_m_we & grant_q);
  assign o_addr    = busy ? addr_mux : '0;
  assign o_dat     = busy ? dat_mux : '0;
  assign o_rdat    = i_dat;

endmodule

// File: tb/tb_bus_arbiter_n.sv
module tb_bus_arbiter_n;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_req;
  logic [N-1:0]  m_we;
  logic [N*16-1:0] m_addr;
  logic [N*8-1:0]  m_dat;
  logic [7:0]    s_dat;
  logic          s_ack;

  logic [N-1:0]  f_grant, f_ack, f_err;
  logic [7:0]    f_rdat, f_dat;
  logic [15:0]   f_addr;
  logic          f_we, f_cs, f_busy;

  logic [N-1:0]  r_grant, r_ack, r_err;
  logic [7:0]    r_rdat, r_dat;
  logic [15:0]   r_addr;
  logic          r_we, r_cs, r_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(16), .DATA_W(8), .RR_MODE(0), .TIMEOUT(4)) dut_fix (
    .i_clk(clk), .i_reset(rst), .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr),
    .i_m_dat(m_dat), .o_m_grant(f_grant), .o_m_ack(f_ack), .o_m_err(f_err),
    .o_rdat(f_rdat), .o_addr(f_addr), .o_dat(f_dat), .o_we(f_we), .o_cs(f_cs),
    .i_dat(s_dat), .i_ack(s_ack), .o_busy(f_busy)
  );

  bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(16), .DATA_W(8), .RR_MODE(1), .TIMEOUT(4)) dut_rr (
    .i_clk(clk), .i_reset(rst), .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr),
    .i_m_dat(m_dat), .o_m_grant(r_grant), .o_m_ack(r_ack), .o_m_err(r_err),
    .o_rdat(r_rdat), .o_addr(r_addr), .o_dat(r_dat), .o_we(r_we), .o_cs(r_cs),
    .i_dat(s_dat), .i_ack(s_ack), .o_busy(r_busy)
  );

  typedef struct {
    logic [2:0]  req;
    logic        ack;
    logic [2:0]  g;
    logic [2:0]  a;
    logic [2:0]  e;
    logic        cs;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  dat;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic [2:0] req, input logic ack, input logic [2:0] g,
                              input logic [2:0] a, input logic [2:0] e, input logic cs,
                              input logic we, input logic [15:0] addr, input logic [7:0] dat);
    vec_t v;
    v.req = req; v.ack = ack; v.g = g; v.a = a; v.e = e;
    v.cs = cs; v.we = we; v.addr = addr; v.dat = dat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Master k: addr 0x1000 + k*0x111, data 0xA0 + k; masters 0 and 1 write.
    m_addr = {16'h1222, 16'h1111, 16'h1000};
    m_dat  = {8'hA2, 8'hA1, 8'hA0};
    m_we   = 3'b011;
    m_req  = '0;
    s_ack  = 1'b0;
    s_dat  = 8'h00;
    rst    = 1'b1;

    //            req     ack   grant   ack     err     cs    we    addr      dat
    tbl[0]  = mk(3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
    tbl[1]  = mk(3'b110, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
    tbl[2]  = mk(3'b110, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 16'h1111, 8'hA1);
    tbl[3]  = mk(3'b100, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
    tbl[4]  = mk(3'b100, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[5]  = mk(3'b100, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[6]  = mk(3'b100, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[7]  = mk(3'b100, 1'b0, 3'b100, 3'b000, 3'b100, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[8]  = mk(3'b100, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
    tbl[9]  = mk(3'b100, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[10] = mk(3'b100, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[11] = mk(3'b100, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[12] = mk(3'b100, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 1'b0, 16'h1222, 8'hA2);
    tbl[13] = mk(3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
    tbl[14] = mk(3'b011, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
    tbl[15] = mk(3'b010, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1, 1'b1, 16'h1000, 8'hA0);
    tbl[16] = mk(3'b010, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
    tbl[17] = mk(3'b010, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 16'h1111, 8'hA1);
    tbl[18] = mk(3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 16'h1111, 8'hA1);
    tbl[19] = mk(3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);

    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Fixed priority: arbitration, timeout, ack-vs-timeout, dropped request.
    for (int r = 0; r < 20; r++) begin
      m_req = tbl[r].req;
      s_ack = tbl[r].ack;
      s_dat = 8'h5A ^ 8'(r);
      @(negedge clk);
      chk($sformatf("fix_grant[%0d]", r), 32'(f_grant), 32'(tbl[r].g));
      chk($sformatf("fix_mack[%0d]", r),  32'(f_ack),   32'(tbl[r].a));
      chk($sformatf("fix_merr[%0d]", r),  32'(f_err),   32'(tbl[r].e));
      chk($sformatf("fix_cs[%0d]", r),    32'(f_cs),    32'(tbl[r].cs));
      chk($sformatf("fix_busy[%0d]", r),  32'(f_busy),  32'(tbl[r].cs));
      chk($sformatf("fix_we[%0d]", r),    32'(f_we),    32'(tbl[r].we));
      chk($sformatf("fix_addr[%0d]", r),  32'(f_addr),  32'(tbl[r].addr));
      chk($sformatf("fix_dat[%0d]", r),   32'(f_dat),   32'(tbl[r].dat));
      chk($sformatf("fix_rdat[%0d]", r),  32'(f_rdat),  32'(8'h5A ^ 8'(r)));
      next_cycle();
    end

    // Round-robin: restart from a clean reset, all requests held, ack always high.
    begin
      logic [2:0] rr_exp [10];
      rr_exp = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
                 3'b000, 3'b001, 3'b000, 3'b010};
      rst = 1'b1;
      m_req = '0;
      s_ack = 1'b0;
      next_cycle();
      rst = 1'b0;
      m_req = 3'b111;
      s_ack = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk($sformatf("rr_grant[%0d]", c), 32'(r_grant), 32'(rr_exp[c]));
        chk($sformatf("rr_mack[%0d]", c),  32'(r_ack),   32'(rr_exp[c]));
        chk($sformatf("rr_cs[%0d]", c),    32'(r_cs),    32'(|rr_exp[c]));
        next_cycle();
      end
    end

    // Round-robin pointer now at master 1: next winner is master 2.
    s_ack = 1'b0;
    @(negedge clk);
    chk("rr_idle_before_m2", 32'(r_busy), 32'd0);
    next_cycle();

    // Reset while master 2 is in BUSY: abandoned with no ack or err.
    rst = 1'b1;
    @(negedge clk);
    chk("rr_m2_grant", 32'(r_grant), 32'(3'b100));
    chk("rr_m2_addr",  32'(r_addr),  32'h1222);
    chk("rr_m2_noack", 32'(r_ack),   32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(r_grant), 32'd0);
    chk("rst_cs",    32'(r_cs),    32'd0);
    chk("rst_busy",  32'(r_busy),  32'd0);
    chk("rst_we",    32'(r_we),    32'd0);
    chk("rst_addr",  32'(r_addr),  32'd0);
    chk("rst_dat",   32'(r_dat),   32'd0);
    chk("rst_mack",  32'(r_ack),   32'd0);
    chk("rst_merr",  32'(r_err),   32'd0);
    next_cycle();
    @(negedge clk);
    chk("rr_restart_grant", 32'(r_grant), 32'(3'b001));
    chk("rr_restart_addr",  32'(r_addr),  32'h1000);
    chk("rr_restart_noerr", 32'(r_err),   32'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
